tuner_phy_ctrl_seq: RTL and testbench

//  Host-facing sequencer for one ring tuner PHY: accepts tuner_cmd_e commands, starts and stops the search and lock engines, supervises them with timeout and bounded retry, and reports a tuner_state_e summary.

---
 rtl/tuner_phy_pkg.sv | 64 ++++++
 rtl/tuner_ctrl_timer.sv | 26 ++
 rtl/tuner_phy_ctrl_seq.sv | 174 +++++++++++++++++
 tb/tb_tuner_phy_ctrl_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner PHY control path: host commands, engine status codes,
// the controller FSM state and the helpers that map/validate them.
package tuner_phy_pkg;

    typedef enum logic [4:0] {
        CMD_INIT   = 5'd0,
        CMD_SEARCH = 5'd1,
        CMD_LOCK   = 5'd2,
        CMD_UNLOCK = 5'd3,
        CMD_CAL    = 5'd4
    } tuner_cmd_e;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'd0,
        ST_ACTIVE = 5'd1,
        ST_DONE   = 5'd2,
        ST_ERROR  = 5'd3
    } tuner_state_e;

    typedef enum logic [4:0] {
        SEARCH_IDLE  = 5'd0,
        SEARCH_BUSY  = 5'd1,
        SEARCH_DONE  = 5'd2,
        SEARCH_ERROR = 5'd3,
        SEARCH_INTR  = 5'd4
    } tuner_phy_search_state_e;

    typedef enum logic [4:0] {
        LOCK_IDLE  = 5'd0,
        LOCK_ACQ   = 5'd1,
        LOCK_TRACK = 5'd2,
        LOCK_ERROR = 5'd3,
        LOCK_INTR  = 5'd4
    } tuner_phy_lock_state_e;

    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_SEARCH = 3'd1,
        C_SDONE  = 3'd2,
        C_LOCK   = 3'd3,
        C_TRACK  = 3'd4,
        C_ERROR  = 3'd5
    } tuner_ctrl_state_e;

    function automatic tuner_state_e ctrl_to_tuner_state(input tuner_ctrl_state_e st);
        case (st)
            C_IDLE:           return ST_IDLE;
            C_SEARCH, C_LOCK: return ST_ACTIVE;
            C_SDONE, C_TRACK: return ST_DONE;
            default:          return ST_ERROR;
        endcase
    endfunction

    function automatic logic is_cmd_legal(input tuner_ctrl_state_e st, input tuner_cmd_e cmd);
        case (cmd)
            CMD_INIT:   return st inside {C_IDLE, C_SDONE, C_TRACK, C_ERROR};
            CMD_SEARCH: return st inside {C_IDLE, C_SDONE};
            CMD_LOCK:   return st == C_SDONE;
            CMD_UNLOCK: return st == C_TRACK;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tuner_ctrl_timer.sv
// Per-attempt watchdog: clear/enable saturating up-counter, timeout flag at TIMEOUT_CYCLES-1.
module tuner_ctrl_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TC = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && cnt != TC) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = (cnt == TC);

endmodule

// File: rtl/tuner_phy_ctrl_seq.sv
// Host-facing sequencer for one ring tuner PHY: command decode, engine start/stop, timeout and retry.
// Build option TUNER_CTRL_AUTO_RELOCK_EN: lock loss in C_TRACK re-runs search then lock instead of erroring.
//
// state    | meaning
// C_IDLE   | nothing running, waiting for SEARCH
// C_SEARCH | search engine running under the timer
// C_SDONE  | search result held, LOCK or another SEARCH allowed
// C_LOCK   | lock engine acquiring under the timer
// C_TRACK  | lock engine tracking
// C_ERROR  | retries exhausted or lock lost, only INIT leaves
module tuner_phy_ctrl_seq
    import tuner_phy_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 4096,
    parameter  int MAX_RETRY      = 3,
    localparam int RTY_W          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    input  logic [4:0]       i_cmd,
    output logic             o_cmd_ready,
    output logic             o_cmd_illegal,
    output logic             o_search_start,
    input  logic [4:0]       i_search_state,
    output logic             o_lock_start,
    output logic             o_lock_stop,
    input  logic [4:0]       i_lock_state,
    output logic [4:0]       o_state,
    output logic [4:0]       o_last_cmd,
    output logic [RTY_W-1:0] o_retry_cnt
);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

    tuner_ctrl_state_e       state;
    tuner_cmd_e              cmd;
    tuner_phy_search_state_e s_st;
    tuner_phy_lock_state_e   l_st;
    logic                    relock;
    logic                    accept;
    logic                    cmd_legal;
    logic                    active;
    logic                    eng_done;
    logic                    eng_fail;
    logic                    attempt_fail;
    logic                    lock_loss;
    logic                    tmr_clr;
    logic                    tmr_timeout;

    assign cmd       = tuner_cmd_e'(i_cmd);
    assign s_st      = tuner_phy_search_state_e'(i_search_state);
    assign l_st      = tuner_phy_lock_state_e'(i_lock_state);
    assign accept    = i_cmd_valid && o_cmd_ready;
    assign cmd_legal = is_cmd_legal(state, cmd);
    assign active    = (state == C_SEARCH) || (state == C_LOCK);

    assign eng_done = ((state == C_SEARCH) && (s_st == SEARCH_DONE)) ||
                      ((state == C_LOCK)   && (l_st == LOCK_TRACK));
    assign eng_fail = ((state == C_SEARCH) && (s_st == SEARCH_ERROR || s_st == SEARCH_INTR)) ||
                      ((state == C_LOCK)   && (l_st == LOCK_ERROR   || l_st == LOCK_INTR));
    // A completing engine beats a timeout landing on the same cycle.
    assign attempt_fail = active && !eng_done && (eng_fail || tmr_timeout);
    assign lock_loss    = (state == C_TRACK) && (l_st == LOCK_ERROR);

    // Timer restarts on the same edge that issues any start pulse, so it reads 0 in the pulse cycle.
    assign tmr_clr = !active || eng_done || attempt_fail;

    tuner_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (active),
        .timeout (tmr_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= C_IDLE;
            o_state        <= ST_IDLE;
            o_cmd_ready    <= 1'b1;
            o_last_cmd     <= CMD_INIT;
            o_retry_cnt    <= '0;
            relock         <= 1'b0;
            o_cmd_illegal  <= 1'b0;
            o_search_start <= 1'b0;
            o_lock_start   <= 1'b0;
            o_lock_stop    <= 1'b0;
        end else begin
            o_cmd_illegal  <= 1'b0;
            o_search_start <= 1'b0;
            o_lock_start   <= 1'b0;
            o_lock_stop    <= 1'b0;
            if (accept) begin
                if (!cmd_legal) begin
                    o_cmd_illegal <= 1'b1;
                end else begin
                    o_last_cmd <= cmd;
                    case (cmd)
                        CMD_INIT: begin
                            state       <= C_IDLE;
                            o_state     <= ctrl_to_tuner_state(C_IDLE);
                            o_cmd_ready <= 1'b1;
                            o_retry_cnt <= '0;
                            relock      <= 1'b0;
                            o_lock_stop <= (state == C_TRACK);
                        end
                        CMD_SEARCH: begin
                            state          <= C_SEARCH;
                            o_state        <= ctrl_to_tuner_state(C_SEARCH);
                            o_cmd_ready    <= 1'b0;
                            o_search_start <= 1'b1;
                        end
                        CMD_LOCK: begin
                            state        <= C_LOCK;
                            o_state      <= ctrl_to_tuner_state(C_LOCK);
                            o_cmd_ready  <= 1'b0;
                            o_lock_start <= 1'b1;
                        end
                        CMD_UNLOCK: begin
                            state       <= C_SDONE;
                            o_state     <= ctrl_to_tuner_state(C_SDONE);
                            o_cmd_ready <= 1'b1;
                            o_lock_stop <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (attempt_fail) begin
                if (o_retry_cnt < RETRY_MAX) begin
                    o_retry_cnt    <= o_retry_cnt + 1'b1;
                    o_search_start <= (state == C_SEARCH);
                    o_lock_start   <= (state == C_LOCK);
                end else begin
                    state       <= C_ERROR;
                    o_state     <= ctrl_to_tuner_state(C_ERROR);
                    o_cmd_ready <= 1'b1;
                    relock      <= 1'b0;
                end
            end else if (eng_done) begin
                o_retry_cnt <= '0;
                if (state == C_LOCK) begin
                    state       <= C_TRACK;
                    o_state     <= ctrl_to_tuner_state(C_TRACK);
                    o_cmd_ready <= 1'b1;
                    relock      <= 1'b0;
                end else if (relock) begin
                    state        <= C_LOCK;
                    o_state      <= ctrl_to_tuner_state(C_LOCK);
                    o_cmd_ready  <= 1'b0;
                    o_lock_start <= 1'b1;
                end else begin
                    state       <= C_SDONE;
                    o_state     <= ctrl_to_tuner_state(C_SDONE);
                    o_cmd_ready <= 1'b1;
                end
            end else if (lock_loss) begin
`ifdef TUNER_CTRL_AUTO_RELOCK_EN
                state          <= C_SEARCH;
                o_state        <= ctrl_to_tuner_state(C_SEARCH);
                o_cmd_ready    <= 1'b0;
                o_search_start <= 1'b1;
                relock         <= 1'b1;
`else
                state       <= C_ERROR;
                o_state     <= ctrl_to_tuner_state(C_ERROR);
                o_cmd_ready <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tuner_phy_ctrl_seq.sv
// Self-checking bench for tuner_phy_ctrl_seq: engine pulses go through an expected-event queue,
// summary state is checked directly after each step.
`timescale 1ns/1ps
module tb_tuner_phy_ctrl_seq;
    import tuner_phy_pkg::*;

    localparam int TO = 16;
    localparam int MR = 3;
    localparam int EV_NONE = 0;
    localparam int EV_SS   = 1;
    localparam int EV_LS   = 2;
    localparam int EV_STOP = 3;
    localparam int EV_ILL  = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cmd_valid = 1'b0;
    logic [4:0] i_cmd = 5'd0;
    logic [4:0] i_search_state = 5'd0;
    logic [4:0] i_lock_state = 5'd0;
    logic       o_cmd_ready;
    logic       o_cmd_illegal;
    logic       o_search_start;
    logic       o_lock_start;
    logic       o_lock_stop;
    logic [4:0] o_state;
    logic [4:0] o_last_cmd;
    logic [1:0] o_retry_cnt;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    ev_t exp_q[$];

    tuner_phy_ctrl_seq #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(MR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .o_cmd_ready    (o_cmd_ready),
        .o_cmd_illegal  (o_cmd_illegal),
        .o_search_start (o_search_start),
        .i_search_state (i_search_state),
        .o_lock_start   (o_lock_start),
        .o_lock_stop    (o_lock_stop),
        .i_lock_state   (i_lock_state),
        .o_state        (o_state),
        .o_last_cmd     (o_last_cmd),
        .o_retry_cnt    (o_retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_pulse", kind, EV_NONE);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_pulse_kind", kind, e.kind);
            check_eq("sb_pulse_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_search_start) sb_pop(EV_SS);
            if (o_lock_start)   sb_pop(EV_LS);
            if (o_lock_stop)    sb_pop(EV_STOP);
            if (o_cmd_illegal)  sb_pop(EV_ILL);
        end
    end

    task automatic send_cmd(input tuner_cmd_e c, input int ev);
        int n = 0;
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        while (o_cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_ready", int'(o_cmd_ready), 1);
        if (ev != EV_NONE) sb_push(ev, cyc + 1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic check_state(input string tag, input tuner_state_e st);
        check_eq(tag, int'(o_state), int'(st));
    endtask

    task automatic do_search(input int dly);
        send_cmd(CMD_SEARCH, EV_SS);
        check_state("search_active", ST_ACTIVE);
        i_search_state = SEARCH_BUSY;
        repeat (dly - 1) @(negedge clk);
        i_search_state = SEARCH_DONE;
        @(negedge clk);
        i_search_state = SEARCH_IDLE;
        check_state("search_done", ST_DONE);
        check_eq("search_retry", int'(o_retry_cnt), 0);
    endtask

    task automatic do_lock(input int dly);
        send_cmd(CMD_LOCK, EV_LS);
        check_state("lock_active", ST_ACTIVE);
        check_eq("lock_ready", int'(o_cmd_ready), 0);
        i_lock_state = LOCK_ACQ;
        repeat (dly - 1) @(negedge clk);
        i_lock_state = LOCK_TRACK;
        @(negedge clk);
        check_state("lock_track", ST_DONE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        i_search_state = SEARCH_IDLE;
        i_lock_state   = LOCK_IDLE;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("rst_state", ST_IDLE);
        check_eq("rst_last_cmd", int'(o_last_cmd), int'(CMD_INIT));
        check_eq("rst_ready", int'(o_cmd_ready), 1);
        check_eq("rst_retry", int'(o_retry_cnt), 0);
        check_eq("rst_pulses", int'({o_search_start, o_lock_start, o_lock_stop, o_cmd_illegal}), 0);

        // T1 search then lock
        do_search(12);
        do_lock(10);
        check_eq("t1_last_cmd", int'(o_last_cmd), int'(CMD_LOCK));

        // T4 unlock then relock by host
        send_cmd(CMD_UNLOCK, EV_STOP);
        i_lock_state = LOCK_IDLE;
        check_state("t4_unlock_sdone", ST_DONE);
        check_eq("t4_last_cmd", int'(o_last_cmd), int'(CMD_UNLOCK));
        do_lock(4);

        // T5 lock loss while tracking
        i_lock_state = LOCK_ERROR;
`ifdef TUNER_CTRL_AUTO_RELOCK_EN
        sb_push(EV_SS, cyc + 1);
        @(negedge clk);
        i_lock_state = LOCK_IDLE;
        check_state("t5_relock_search", ST_ACTIVE);
        repeat (2) @(negedge clk);
        i_search_state = SEARCH_DONE;
        sb_push(EV_LS, cyc + 1);
        @(negedge clk);
        i_search_state = SEARCH_IDLE;
        check_state("t5_relock_lock", ST_ACTIVE);
        check_eq("t5_relock_ready", int'(o_cmd_ready), 0);
        repeat (2) @(negedge clk);
        i_lock_state = LOCK_TRACK;
        @(negedge clk);
        check_state("t5_relock_track", ST_DONE);
        check_eq("t5_last_cmd", int'(o_last_cmd), int'(CMD_LOCK));
        send_cmd(CMD_INIT, EV_STOP);
        i_lock_state = LOCK_IDLE;
`else
        @(negedge clk);
        i_lock_state = LOCK_IDLE;
        check_state("t5_loss_error", ST_ERROR);
        check_eq("t5_error_ready", int'(o_cmd_ready), 1);
        send_cmd(CMD_INIT, EV_NONE);
`endif
        check_state("t5_init_idle", ST_IDLE);

        // INIT from tracking stops the lock engine
        do_search(3);
        do_lock(3);
        send_cmd(CMD_INIT, EV_STOP);
        i_lock_state = LOCK_IDLE;
        check_state("t7_init_idle", ST_IDLE);
        check_eq("t7_last_cmd", int'(o_last_cmd), int'(CMD_INIT));

        // T3 illegal commands
        send_cmd(CMD_LOCK, EV_ILL);
        check_state("t3_lock_idle", ST_IDLE);
        check_eq("t3_last_cmd_a", int'(o_last_cmd), int'(CMD_INIT));
        do_search(5);
        send_cmd(CMD_UNLOCK, EV_ILL);
        check_state("t3_unlock_sdone", ST_DONE);
        check_eq("t3_last_cmd_b", int'(o_last_cmd), int'(CMD_SEARCH));
        send_cmd(CMD_CAL, EV_ILL);
        check_state("t3_cal_sdone", ST_DONE);

        // T6b done on the timeout cycle wins
        send_cmd(CMD_SEARCH, EV_SS);
        e0 = cyc;
        i_search_state = SEARCH_BUSY;
        while (cyc < e0 + TO - 1) @(negedge clk);
        i_search_state = SEARCH_DONE;
        @(negedge clk);
        i_search_state = SEARCH_IDLE;
        check_state("t6b_done_wins", ST_DONE);
        check_eq("t6b_retry", int'(o_retry_cnt), 0);
        repeat (TO + 4) @(negedge clk);
        check_state("t6b_still_sdone", ST_DONE);

        // T6a reset in the middle of a lock attempt
        send_cmd(CMD_LOCK, EV_LS);
        i_lock_state = LOCK_ACQ;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_lock_state = LOCK_IDLE;
        check_state("t6a_state", ST_IDLE);
        check_eq("t6a_ready", int'(o_cmd_ready), 1);
        check_eq("t6a_last_cmd", int'(o_last_cmd), int'(CMD_INIT));
        check_eq("t6a_pulses", int'({o_search_start, o_lock_start, o_lock_stop, o_cmd_illegal}), 0);
        @(negedge clk);
        check_eq("t6a_no_stop", int'(o_lock_stop), 0);

        // T2 search never finishes: retries then error
        send_cmd(CMD_SEARCH, EV_SS);
        e0 = cyc;
        for (int k = 1; k <= MR; k++) sb_push(EV_SS, e0 + k * TO);
        i_search_state = SEARCH_BUSY;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cyc == e0 + TO + 4) check_eq("t2_retry_mid", int'(o_retry_cnt), 1);
            if (o_state == 5'(ST_ERROR)) break;
        end
        check_eq("t2_error_cycle", cyc, e0 + (MR + 1) * TO);
        check_state("t2_error", ST_ERROR);
        check_eq("t2_retry", int'(o_retry_cnt), MR);
        send_cmd(CMD_SEARCH, EV_ILL);
        check_state("t2_search_in_error", ST_ERROR);
        check_eq("t2_retry_hold", int'(o_retry_cnt), MR);
        i_search_state = SEARCH_IDLE;
        send_cmd(CMD_INIT, EV_NONE);
        check_state("t2_init_idle", ST_IDLE);
        check_eq("t2_retry_clr", int'(o_retry_cnt), 0);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
